// File: rtl/fpu_seq_pkg.sv
// Shared definitions for the FPU operation sequencer: register offsets,
// sequencer states and the values forced into RESULT/FLAGS on a timeout.
package fpu_seq_pkg;

  localparam logic [7:0] OFF_A      = 8'h00;
  localparam logic [7:0] OFF_B      = 8'h04;
  localparam logic [7:0] OFF_C      = 8'h08;
  localparam logic [7:0] OFF_RESULT = 8'h0C;
  localparam logic [7:0] OFF_FLAGS  = 8'h10;
  localparam logic [7:0] OFF_STATUS = 8'h14;
  localparam logic [7:0] OFF_IRQ_EN = 8'h18;
  localparam logic [7:0] OFF_OP     = 8'h1C;
  localparam logic [7:0] OFF_RM     = 8'h24;

  localparam logic [31:0] CANON_NAN = 32'h7FC0_0000;
  localparam logic [4:0]  FLAG_NV   = 5'b10000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } seq_state_e;

  function automatic logic [31:0] apply_sel(input logic [31:0] old_v,
                                            input logic [31:0] new_v,
                                            input logic [3:0]  sel);
    logic [31:0] mask;
    mask = {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
    return (old_v & ~mask) | (new_v & mask);
  endfunction

endpackage

// File: rtl/fpu_seq_wb_regs.sv
// Wishbone slave decode and register file of the FPU sequencer; the
// sequencer core reports completion through the cap_* event inputs.
module fpu_seq_wb_regs
  import fpu_seq_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  input  logic        busy_i,
  input  logic        cap_valid_i,
  input  logic        cap_timeout_i,
  input  logic [31:0] fpu_result_i,
  input  logic [4:0]  fpu_flags_i,
  output logic [31:0] a_o,
  output logic [31:0] b_o,
  output logic [31:0] c_o,
  output logic [2:0]  rm_o,
  output logic [12:0] op_o,
  output logic        start_o,
  output logic        irq_o
);

  logic        ack_q, start_q, done_q, timeout_q, irq_en_q;
  logic [31:0] dat_q, a_q, b_q, c_q, result_q;
  logic [4:0]  flags_q;
  logic [2:0]  rm_q;
  logic [12:0] op_q;

  logic        ack_d, start_d, done_d, timeout_d, irq_en_d;
  logic [31:0] dat_d, a_d, b_d, c_d, result_d, rdata_s;
  logic [4:0]  flags_d;
  logic [2:0]  rm_d;
  logic [12:0] op_d;

  logic        acc_s, wr_s, cfg_wr_s, w1c_s;
  logic [7:0]  off_s;

  // The ack cycle itself never decodes, so a held strobe cannot be re-acked.
  assign off_s    = wbs_adr_i[7:0];
  assign acc_s    = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:8] == BASE_ADDR[31:8]) & ~ack_q;
  assign wr_s     = acc_s & wbs_we_i;
  assign cfg_wr_s = wr_s & ~busy_i;
  assign w1c_s    = wr_s & (off_s == OFF_STATUS);

  assign ack_d    = acc_s;
  assign dat_d    = (acc_s && !wbs_we_i) ? rdata_s : 32'h0000_0000;
  assign start_d  = cfg_wr_s & (off_s == OFF_OP) & wbs_dat_i[13];
  assign a_d      = (cfg_wr_s && off_s == OFF_A) ? apply_sel(a_q, wbs_dat_i, wbs_sel_i) : a_q;
  assign b_d      = (cfg_wr_s && off_s == OFF_B) ? apply_sel(b_q, wbs_dat_i, wbs_sel_i) : b_q;
  assign c_d      = (cfg_wr_s && off_s == OFF_C) ? apply_sel(c_q, wbs_dat_i, wbs_sel_i) : c_q;
  assign rm_d     = (cfg_wr_s && off_s == OFF_RM) ? wbs_dat_i[2:0] : rm_q;
  assign op_d     = (cfg_wr_s && off_s == OFF_OP) ? wbs_dat_i[12:0] : op_q;
  assign irq_en_d = (wr_s && off_s == OFF_IRQ_EN) ? wbs_dat_i[0] : irq_en_q;

  // Completion events take priority over software clears in the same cycle.
  assign done_d    = cap_valid_i ? 1'b1 :
                     (start_d || (w1c_s && wbs_dat_i[1])) ? 1'b0 : done_q;
  assign timeout_d = cap_timeout_i ? 1'b1 :
                     (start_d || (w1c_s && wbs_dat_i[2])) ? 1'b0 : timeout_q;
  assign result_d  = cap_valid_i ? fpu_result_i : (cap_timeout_i ? CANON_NAN : result_q);
  assign flags_d   = cap_valid_i ? fpu_flags_i  : (cap_timeout_i ? FLAG_NV   : flags_q);

  // Read-data multiplexer over the register map.
  always_comb begin
    rdata_s = 32'h0000_0000;
    case (off_s)
      OFF_A:      rdata_s = a_q;
      OFF_B:      rdata_s = b_q;
      OFF_C:      rdata_s = c_q;
      OFF_RESULT: rdata_s = result_q;
      OFF_FLAGS:  rdata_s = {27'd0, flags_q};
      OFF_STATUS: rdata_s = {29'd0, timeout_q, done_q, busy_i};
      OFF_IRQ_EN: rdata_s = {31'd0, irq_en_q};
      OFF_OP:     rdata_s = {19'd0, op_q};
      OFF_RM:     rdata_s = {29'd0, rm_q};
      default:    rdata_s = 32'h0000_0000;
    endcase
  end

  // Register file state update.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ack_q     <= 1'b0;
      dat_q     <= 32'h0000_0000;
      start_q   <= 1'b0;
      a_q       <= 32'h0000_0000;
      b_q       <= 32'h0000_0000;
      c_q       <= 32'h0000_0000;
      rm_q      <= 3'd0;
      op_q      <= 13'd0;
      irq_en_q  <= 1'b0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
      result_q  <= 32'h0000_0000;
      flags_q   <= 5'd0;
    end else begin
      ack_q     <= ack_d;
      dat_q     <= dat_d;
      start_q   <= start_d;
      a_q       <= a_d;
      b_q       <= b_d;
      c_q       <= c_d;
      rm_q      <= rm_d;
      op_q      <= op_d;
      irq_en_q  <= irq_en_d;
      done_q    <= done_d;
      timeout_q <= timeout_d;
      result_q  <= result_d;
      flags_q   <= flags_d;
    end
  end

  assign wbs_ack_o = ack_q;
  assign wbs_dat_o = dat_q;
  assign a_o       = a_q;
  assign b_o       = b_q;
  assign c_o       = c_q;
  assign rm_o      = rm_q;
  assign op_o      = op_q;
  assign start_o   = start_q;
  assign irq_o     = irq_en_q & (done_q | timeout_q);

endmodule

// File: rtl/fpu_op_sequencer.sv
// Wishbone-controlled FPU operation sequencer: launches one FPU operation per
// start command and collects its result, aborting after TIMEOUT wait cycles.
module fpu_op_sequencer
  import fpu_seq_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter logic [15:0] TIMEOUT   = 16'd255
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic [31:0] fpu_a_o,
  output logic [31:0] fpu_b_o,
  output logic [31:0] fpu_c_o,
  output logic [2:0]  fpu_rm_o,
  output logic [12:0] fpu_op_o,
  output logic        fpu_valid_o,
  input  logic [31:0] fpu_result_i,
  input  logic [4:0]  fpu_flags_i,
  input  logic        fpu_valid_i,
  output logic        irq_o
);

  seq_state_e  state_q;
  logic [15:0] cnt_q;
  logic        valid_q;

  logic        start_s, busy_s, cap_valid_s, cap_timeout_s;
  logic [15:0] cnt_inc_s;

  // cnt_q counts completed WAIT cycles; the TIMEOUT-th one is terminal.
  assign busy_s        = (state_q != ST_IDLE);
  assign cnt_inc_s     = cnt_q + 16'd1;
  assign cap_valid_s   = (state_q == ST_WAIT) & fpu_valid_i;
  assign cap_timeout_s = (state_q == ST_WAIT) & ~fpu_valid_i & (cnt_inc_s >= TIMEOUT);

  fpu_seq_wb_regs #(
    .BASE_ADDR (BASE_ADDR)
  ) u_regs (
    .clk_i         (wb_clk_i),
    .rst_i         (wb_rst_i),
    .wbs_cyc_i     (wbs_cyc_i),
    .wbs_stb_i     (wbs_stb_i),
    .wbs_we_i      (wbs_we_i),
    .wbs_sel_i     (wbs_sel_i),
    .wbs_adr_i     (wbs_adr_i),
    .wbs_dat_i     (wbs_dat_i),
    .wbs_ack_o     (wbs_ack_o),
    .wbs_dat_o     (wbs_dat_o),
    .busy_i        (busy_s),
    .cap_valid_i   (cap_valid_s),
    .cap_timeout_i (cap_timeout_s),
    .fpu_result_i  (fpu_result_i),
    .fpu_flags_i   (fpu_flags_i),
    .a_o           (fpu_a_o),
    .b_o           (fpu_b_o),
    .c_o           (fpu_c_o),
    .rm_o          (fpu_rm_o),
    .op_o          (fpu_op_o),
    .start_o       (start_s),
    .irq_o         (irq_o)
  );

  // Sequencer FSM with the launch pulse registered alongside the state.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= 16'd0;
      valid_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_s) begin
            state_q <= ST_ISSUE;
            valid_q <= 1'b1;
          end else begin
            state_q <= ST_IDLE;
            valid_q <= 1'b0;
          end
        end
        ST_ISSUE: begin
          state_q <= ST_WAIT;
          valid_q <= 1'b0;
          cnt_q   <= 16'd0;
        end
        ST_WAIT: begin
          valid_q <= 1'b0;
          if (cap_valid_s || cap_timeout_s) begin
            state_q <= ST_IDLE;
          end else begin
            cnt_q <= cnt_inc_s;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign fpu_valid_o = valid_q;

endmodule

// File: tb/tb_fpu_op_sequencer.sv
// Self-checking bench for fpu_op_sequencer with a delay-programmable FPU model.
module tb_fpu_op_sequencer;

  localparam logic [31:0] BASE = 32'h3000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
  logic [3:0]  sel = 4'h0;
  logic [31:0] adr = 32'h0, dat = 32'h0;
  logic        ack;
  logic [31:0] dat_o, fa, fb, fc;
  logic [2:0]  frm;
  logic [12:0] fop;
  logic        fvo, irq;
  logic [31:0] fres = 32'h0;
  logic [4:0]  fflags = 5'h0;
  logic        fvi = 1'b0;

  int n_checks = 0;
  int n_fail = 0;
  int cycle = 0;
  int vld_pulses = 0;
  int resp_cnt = 0;
  int model_delay = 0;
  int manual_req = 0;
  int manual_seen = 0;
  logic [31:0] model_result = 32'h0;
  logic [4:0]  model_flags = 5'h0;
  logic [31:0] exp_q[$];

  fpu_op_sequencer dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we), .wbs_sel_i(sel),
    .wbs_adr_i(adr), .wbs_dat_i(dat), .wbs_ack_o(ack), .wbs_dat_o(dat_o),
    .fpu_a_o(fa), .fpu_b_o(fb), .fpu_c_o(fc), .fpu_rm_o(frm), .fpu_op_o(fop),
    .fpu_valid_o(fvo), .fpu_result_i(fres), .fpu_flags_i(fflags),
    .fpu_valid_i(fvi), .irq_o(irq)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle++;

  // FPU model: answers model_delay cycles after a launch (0 = never).
  always @(negedge clk) begin
    fvi = 1'b0;
    if (fvo) begin
      vld_pulses++;
      resp_cnt = model_delay;
    end else if (resp_cnt > 0) begin
      resp_cnt--;
      if (resp_cnt == 0) begin
        fvi = 1'b1;
        fres = model_result;
        fflags = model_flags;
      end
    end
    if (manual_req != manual_seen) begin
      fvi = 1'b1;
      manual_seen = manual_req;
    end
  end

  task automatic wb_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          output bit ok);
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = a; dat = d; sel = s; ok = 1'b0;
    for (int i = 0; i < 4 && !ok; i++) begin
      @(negedge clk);
      if (ack) ok = 1'b1;
    end
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  task automatic wb_read(input logic [31:0] a, output logic [31:0] d, output bit ok);
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = a; sel = 4'hF; ok = 1'b0; d = 32'hDEAD_BEEF;
    for (int i = 0; i < 4 && !ok; i++) begin
      @(negedge clk);
      if (ack) begin ok = 1'b1; d = dat_o; end
    end
    cyc = 1'b0; stb = 1'b0;
  endtask

  task automatic start_op(input logic [12:0] op, output int issue_cyc, output bit vld_seen);
    bit ok;
    wb_write(BASE + 32'h1C, {18'd0, 1'b1, op}, 4'hF, ok);
    @(negedge clk);
    vld_seen = fvo;
    issue_cyc = cycle;
  endtask

  task automatic wait_irq(input int budget, output int rise_cyc, output bit seen);
    seen = 1'b0;
    rise_cyc = -1;
    for (int i = 0; i < budget && !seen; i++) begin
      if (irq) begin seen = 1'b1; rise_cyc = cycle; end
      else @(negedge clk);
    end
  endtask

  task automatic test_reset();
    logic [31:0] rd; bit ok;
    repeat (3) @(negedge clk);
    n_checks++; if (ack !== 1'b0) begin n_fail++; $display("FAIL reset_ack: got %b expected 0", ack); end
    n_checks++; if (fvo !== 1'b0) begin n_fail++; $display("FAIL reset_fpu_valid: got %b expected 0", fvo); end
    n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL reset_irq: got %b expected 0", irq); end
    n_checks++; if ({fa, fop} !== 45'd0) begin n_fail++; $display("FAIL reset_operands: got a=%h op=%h expected 0", fa, fop); end
    rst = 1'b0;
    exp_q.push_back(32'h0);
    wb_read(BASE + 32'h14, rd, ok);
    n_checks++; if (rd !== exp_q.pop_front()) begin n_fail++; $display("FAIL reset_status: got %h expected 0", rd); end
  endtask

  task automatic test_basic();
    logic [31:0] rd, e; bit ok, vs, seen; int iss, rise, p0;
    wb_write(BASE + 32'h00, 32'h3F80_0000, 4'hF, ok);
    wb_write(BASE + 32'h04, 32'h4000_0000, 4'hF, ok);
    wb_write(BASE + 32'h24, 32'h0, 4'hF, ok);
    wb_write(BASE + 32'h18, 32'h1, 4'hF, ok);
    model_delay = 4; model_result = 32'h4040_0000; model_flags = 5'b00000;
    exp_q.push_back(32'h4040_0000);
    p0 = vld_pulses;
    start_op(13'h0001, iss, vs);
    n_checks++; if (vs !== 1'b1) begin n_fail++; $display("FAIL basic_launch_latency: fpu_valid_o got %b expected 1", vs); end
    n_checks++; if ({fa, fb, fop} !== {32'h3F80_0000, 32'h4000_0000, 13'h0001}) begin
      n_fail++; $display("FAIL basic_operands: got a=%h b=%h op=%h", fa, fb, fop); end
    @(negedge clk);
    n_checks++; if (fvo !== 1'b0) begin n_fail++; $display("FAIL basic_single_pulse: fpu_valid_o got %b expected 0", fvo); end
    wait_irq(20, rise, seen);
    n_checks++; if (rise - iss !== 5) begin n_fail++; $display("FAIL basic_done_latency: got %0d expected 5", rise - iss); end
    wb_read(BASE + 32'h14, rd, ok);
    n_checks++; if (rd !== 32'h2) begin n_fail++; $display("FAIL basic_status: got %h expected 2", rd); end
    wb_read(BASE + 32'h0C, rd, ok);
    e = exp_q.pop_front();
    n_checks++; if (rd !== e) begin n_fail++; $display("FAIL basic_result: got %h expected %h", rd, e); end
    wb_read(BASE + 32'h1C, rd, ok);
    n_checks++; if (rd !== 32'h0001) begin n_fail++; $display("FAIL basic_op_readback: got %h expected 1", rd); end
    n_checks++; if (vld_pulses - p0 !== 1) begin n_fail++; $display("FAIL basic_pulse_count: got %0d expected 1", vld_pulses - p0); end
  endtask

  task automatic test_min_latency();
    bit vs, seen; int iss, rise;
    model_delay = 1; model_result = 32'h3F80_0000; model_flags = 5'b00001;
    start_op(13'h0002, iss, vs);
    wait_irq(20, rise, seen);
    n_checks++; if (rise - iss !== 2) begin n_fail++; $display("FAIL min_latency: got %0d expected 2", rise - iss); end
  endtask

  task automatic test_timeout();
    logic [31:0] rd; bit ok, vs, seen; int iss, rise;
    model_delay = 0;
    exp_q.push_back(32'h7FC0_0000);
    start_op(13'h0004, iss, vs);
    wait_irq(400, rise, seen);
    n_checks++; if (rise - iss !== 256) begin n_fail++; $display("FAIL timeout_latency: got %0d expected 256", rise - iss); end
    wb_read(BASE + 32'h0C, rd, ok);
    n_checks++; if (rd !== exp_q.pop_front()) begin n_fail++; $display("FAIL timeout_result: got %h expected 7fc00000", rd); end
    wb_read(BASE + 32'h10, rd, ok);
    n_checks++; if (rd !== 32'h10) begin n_fail++; $display("FAIL timeout_flags: got %h expected 10", rd); end
    wb_read(BASE + 32'h14, rd, ok);
    n_checks++; if (rd !== 32'h4) begin n_fail++; $display("FAIL timeout_status: got %h expected 4", rd); end
  endtask

  task automatic test_coincident();
    logic [31:0] rd; bit ok, vs, seen; int iss, rise;
    model_delay = 255; model_result = 32'h4120_0000; model_flags = 5'b00001;
    exp_q.push_back(32'h4120_0000);
    start_op(13'h0008, iss, vs);
    wait_irq(400, rise, seen);
    n_checks++; if (rise - iss !== 256) begin n_fail++; $display("FAIL coincident_latency: got %0d expected 256", rise - iss); end
    wb_read(BASE + 32'h14, rd, ok);
    n_checks++; if (rd !== 32'h2) begin n_fail++; $display("FAIL coincident_status: got %h expected 2", rd); end
    wb_read(BASE + 32'h0C, rd, ok);
    n_checks++; if (rd !== exp_q.pop_front()) begin n_fail++; $display("FAIL coincident_result: got %h expected 41200000", rd); end
    wb_read(BASE + 32'h10, rd, ok);
    n_checks++; if (rd !== 32'h1) begin n_fail++; $display("FAIL coincident_flags: got %h expected 1", rd); end
  endtask

  task automatic test_busy_writes();
    logic [31:0] rd; bit ok1, ok2, ok, vs, seen; int iss, rise, p0;
    model_delay = 30; model_result = 32'h4080_0000; model_flags = 5'b00000;
    p0 = vld_pulses;
    start_op(13'h0010, iss, vs);
    wb_write(BASE + 32'h00, 32'hFFFF_FFFF, 4'hF, ok1);
    wb_write(BASE + 32'h1C, 32'h0000_2001, 4'hF, ok2);
    n_checks++; if ({ok1, ok2} !== 2'b11) begin n_fail++; $display("FAIL busy_acks: got %b expected 11", {ok1, ok2}); end
    wb_read(BASE + 32'h14, rd, ok);
    n_checks++; if (rd !== 32'h1) begin n_fail++; $display("FAIL busy_status: got %h expected 1", rd); end
    wait_irq(60, rise, seen);
    repeat (10) @(negedge clk);
    wb_read(BASE + 32'h00, rd, ok);
    n_checks++; if (rd !== 32'h3F80_0000 || fa !== 32'h3F80_0000) begin
      n_fail++; $display("FAIL busy_a_unchanged: got %h/%h expected 3f800000", rd, fa); end
    n_checks++; if (fop !== 13'h0010) begin n_fail++; $display("FAIL busy_op_unchanged: got %h expected 10", fop); end
    n_checks++; if (vld_pulses - p0 !== 1) begin n_fail++; $display("FAIL busy_pulse_count: got %0d expected 1", vld_pulses - p0); end
  endtask

  task automatic test_decode();
    logic [31:0] rd; bit ok;
    wb_read(BASE + 32'h100, rd, ok);
    n_checks++; if (ok !== 1'b0) begin n_fail++; $display("FAIL decode_out_of_window: ack got %b expected 0", ok); end
    wb_write(BASE + 32'h00, 32'h1122_3344, 4'hF, ok);
    wb_write(BASE + 32'h00, 32'hAABB_CCDD, 4'b0001, ok);
    wb_read(BASE + 32'h00, rd, ok);
    n_checks++; if (rd !== 32'h1122_33DD) begin n_fail++; $display("FAIL decode_byte_sel: got %h expected 112233dd", rd); end
    wb_read(BASE + 32'h20, rd, ok);
    n_checks++; if (rd !== 32'h0 || ok !== 1'b1) begin n_fail++; $display("FAIL decode_unmapped: got %h ack %b expected 0/1", rd, ok); end
    n_checks++; if (irq !== 1'b1) begin n_fail++; $display("FAIL w1c_irq_before: got %b expected 1", irq); end
    wb_write(BASE + 32'h14, 32'h6, 4'hF, ok);
    n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL w1c_irq_after: got %b expected 0", irq); end
    wb_read(BASE + 32'h14, rd, ok);
    n_checks++; if (rd !== 32'h0) begin n_fail++; $display("FAIL w1c_status: got %h expected 0", rd); end
  endtask

  task automatic test_reset_abort();
    logic [31:0] rd; bit ok, vs; int iss;
    wb_write(BASE + 32'h18, 32'h1, 4'hF, ok);
    model_delay = 0;
    start_op(13'h0020, iss, vs);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1 manual_req++;
    repeat (4) @(negedge clk);
    wb_read(BASE + 32'h14, rd, ok);
    n_checks++; if (rd !== 32'h0) begin n_fail++; $display("FAIL abort_status: got %h expected 0", rd); end
    wb_read(BASE + 32'h0C, rd, ok);
    n_checks++; if (rd !== 32'h0) begin n_fail++; $display("FAIL abort_result: got %h expected 0", rd); end
    n_checks++; if ({irq, fvo, fa} !== 34'd0) begin n_fail++; $display("FAIL abort_outputs: got irq=%b valid=%b a=%h expected 0", irq, fvo, fa); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_min_latency();
    test_timeout();
    test_coincident();
    test_busy_writes();
    test_decode();
    test_reset_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fpu_op_sequencer.md
FPU_OP_SEQUENCER -- requirements
Module: fpu_op_sequencer

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h3000_0000, meaning the Wishbone base address of the register window.
REQ-002 SHALL have parameter TIMEOUT, default 16'd255, meaning the maximum number of WAIT cycles before an operation aborts.
REQ-003 SHALL have port wb_clk_i, input, 1, the single clock.
REQ-004 SHALL have port wb_rst_i, input, 1, a synchronous active-high reset.
REQ-005 SHALL have ports wbs_cyc_i, wbs_stb_i and wbs_we_i, each input, 1, the Wishbone cycle, strobe and write-enable.
REQ-006 SHALL have port wbs_sel_i, input, 4, the byte selects.
REQ-007 SHALL have ports wbs_adr_i and wbs_dat_i, each input, 32, the Wishbone address and write data.
REQ-008 SHALL have port wbs_ack_o, output, 1, the Wishbone acknowledge.
REQ-009 SHALL have port wbs_dat_o, output, 32, the Wishbone read data.
REQ-010 SHALL have ports fpu_a_o, fpu_b_o and fpu_c_o, each output, 32, the FPU operands.
REQ-011 SHALL have port fpu_rm_o, output, 3, the FPU rounding mode.
REQ-012 SHALL have port fpu_op_o, output, 13, the one-hot FPU operation select.
REQ-013 SHALL have port fpu_valid_o, output, 1, the FPU launch pulse.
REQ-014 SHALL have port fpu_result_i, input, 32, the FPU result.
REQ-015 SHALL have port fpu_flags_i, input, 5, the FPU exception flags in order NV,DZ,OF,UF,NX.
REQ-016 SHALL have port fpu_valid_i, input, 1, the FPU result-valid strobe.
REQ-017 SHALL have port irq_o, output, 1, the interrupt, a level signal.

Function
REQ-018 SHALL decode a Wishbone access only when wbs_cyc_i, wbs_stb_i and wbs_adr_i[31:8]==BASE_ADDR[31:8] are all true; any other address SHALL get no ack.
REQ-019 SHALL assert wbs_ack_o for exactly one cycle, in the cycle after a decoded access, and SHALL NOT re-ack while stb remains high in that ack cycle.
REQ-020 SHALL implement this register map (offset, access, contents):
- 0x00 RW A; 0x04 RW B; 0x08 RW C.
- 0x0C RO RESULT; 0x10 RO FLAGS[4:0].
- 0x14 STATUS: bit0 busy (RO); bit1 done (W1C); bit2 timeout (W1C).
- 0x18 RW IRQ_EN[0].
- 0x1C RW OP: [12:0] op, [13] start; start is write-only and reads 0.
- 0x24 RW RM[2:0].
- Unmapped offsets read 0 and ignore writes.
REQ-021 Writes to A, B and C SHALL honour wbs_sel_i per byte; writes to the other registers SHALL use the full word.
REQ-022 The FSM SHALL have states IDLE, ISSUE and WAIT, with busy=1 in ISSUE and WAIT.
REQ-023 In IDLE, an acked write to OP with bit13=1 SHALL latch op[12:0], clear done and timeout, and move to ISSUE next cycle.
REQ-024 In ISSUE, the block SHALL assert fpu_valid_o for exactly one cycle, clear the WAIT counter, then go to WAIT.
REQ-025 In WAIT, when fpu_valid_i=1 the block SHALL capture fpu_result_i into RESULT and fpu_flags_i into FLAGS, set done, and return to IDLE, with done visible the following cycle.
REQ-026 In WAIT, when the counter reaches TIMEOUT without fpu_valid_i, the block SHALL set RESULT=32'h7FC0_0000, FLAGS=5'b10000 and timeout=1, and return to IDLE.
REQ-027 If fpu_valid_i and the terminal count occur in the same cycle, valid SHALL win and timeout SHALL stay 0.
REQ-028 fpu_valid_i SHALL be ignored in IDLE and ISSUE.
REQ-029 While busy, writes to A, B, C, RM and OP SHALL be acked and discarded; reads SHALL work normally.
REQ-030 fpu_a_o, fpu_b_o, fpu_c_o, fpu_rm_o and fpu_op_o SHALL be driven directly from their registers.
REQ-031 irq_o SHALL equal IRQ_EN[0] & (done | timeout).
REQ-032 Latency: start write acked in cycle T gives fpu_valid_o=1 in cycle T+1; minimum completion is T+3 when fpu_valid_i arrives in cycle T+2.

Reset
REQ-033 When wb_rst_i=1 at a clock edge, the block SHALL clear all registers to 0, set the FSM to IDLE, and drive wbs_ack_o, fpu_valid_o and irq_o low.
REQ-034 A reset during ISSUE or WAIT SHALL abort the operation with no done, no timeout and no RESULT update, and a late fpu_valid_i SHALL be ignored.

Structure
REQ-035 Package fpu_seq_pkg SHALL hold the register offsets, the FSM state enum, the canonical NaN constant and the NV flag constant.
REQ-036 The Wishbone decode and register file SHALL be one sub-module, fpu_seq_wb_regs; the FSM and counter SHALL live in the top module.

Verification
REQ-037 Write A=3F80_0000, B=4000_0000, RM=0, OP=0x2000|op; FPU model returns 4040_0000 after 4 cycles -> one fpu_valid_o pulse; done=1; RESULT=4040_0000; irq_o=1 with IRQ_EN=1.
REQ-038 Start with a model that never responds, TIMEOUT=255 -> timeout set exactly 255 WAIT cycles after ISSUE; RESULT=7FC0_0000; FLAGS=10h.
REQ-039 fpu_valid_i coincident with the terminal count -> done=1, timeout=0, RESULT taken from the model.
REQ-040 While busy, write A=FFFF_FFFF and a second start -> both acked; A unchanged; no second fpu_valid_o.
REQ-041 Assert wb_rst_i mid-WAIT, then pulse fpu_valid_i -> STATUS=0 and RESULT=0.
REQ-042 Access address 0x3000_0100 -> no ack; write sel=4'b0001 to A -> only A[7:0] changes; write 6 to STATUS -> done and timeout cleared and irq_o falls.
